// File: rtl/wam_scr_multi.sv
// Multi-hole whack-a-mole scorer: rising-edge hit detection, saturating packed-BCD score and best-score tracking.
// Optional build macro WAM_MISS_PENALTY_EN: each miss in play subtracts one point, floored at zero.
module wam_scr_multi #(
    parameter int NUM_HOLES   = 8,
    parameter int DIGITS      = 3,
    parameter int PTS_PER_HIT = 1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  start,
    input  logic                  stop,
    input  logic [NUM_HOLES-1:0]  hit,
    input  logic [NUM_HOLES-1:0]  mole,
    output logic [4*DIGITS-1:0]   num,
    output logic [4*DIGITS-1:0]   best,
    output logic                  cout0,
    output logic                  playing
);

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    // 20 bits covers 999999 plus the largest single-cycle gain
    localparam int BW   = 20;
    localparam int MAXV = pow10(DIGITS) - 1;

    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

    state_t               state;
    logic [NUM_HOLES-1:0] hit_q;
    logic [NUM_HOLES-1:0] rise;
    logic [NUM_HOLES-1:0] valid;
    logic [BW-1:0]        score;
    logic [BW-1:0]        next_score;
    logic                 sat;
    int                   net;

    function automatic int popcount(input logic [NUM_HOLES-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < NUM_HOLES; i++) c = c + int'(v[i]);
        return c;
    endfunction

    function automatic logic [4*DIGITS-1:0] to_bcd(input logic [BW-1:0] v);
        logic [4*DIGITS-1:0] b;
        b = '0;
        for (int i = BW - 1; i >= 0; i--) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (b[4*d +: 4] >= 4'd5) b[4*d +: 4] = b[4*d +: 4] + 4'd3;
            end
            b = {b[4*DIGITS-2:0], v[i]};
        end
        return b;
    endfunction

    assign rise    = hit & ~hit_q;
    assign valid   = (state == PLAY && !stop) ? (rise & mole) : '0;
    assign playing = (state == PLAY);

`ifdef WAM_MISS_PENALTY_EN
    logic [NUM_HOLES-1:0] miss;
    assign miss = (state == PLAY && !stop) ? (rise & ~mole) : '0;
`endif

    // score is kept in binary alongside num so the add/clamp stays simple
    always_comb begin
        net = int'(score) + PTS_PER_HIT * popcount(valid);
`ifdef WAM_MISS_PENALTY_EN
        net = net - popcount(miss);
        if (net < 0) net = 0;
`endif
        sat        = (net >= MAXV);
        next_score = sat ? BW'(MAXV) : BW'(net);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            hit_q <= '0;
            score <= '0;
            num   <= '0;
            best  <= '0;
            cout0 <= 1'b0;
        end else begin
            hit_q <= hit;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= PLAY;
                        score <= '0;
                        num   <= '0;
                        cout0 <= 1'b0;
                    end
                end
                PLAY: begin
                    if (stop) begin
                        state <= DONE;
                    end else begin
                        score <= next_score;
                        num   <= to_bcd(next_score);
                        if (sat) cout0 <= 1'b1;
                    end
                end
                DONE: begin
                    // packed BCD orders the same as its numeric value
                    if (num > best) best <= num;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wam_scr_multi.sv
// Self-checking bench for wam_scr_multi: directed vector table, saturation/reset sequences, randomized play vs. a score model.
module tb_wam_scr_multi;

    logic        clk = 1'b0;
    logic        clr;
    logic        start, stop;
    logic [7:0]  hit, mole;
    logic [11:0] num, best;
    logic        cout0, playing;

    int total = 0;
    int bad   = 0;

    // reference model: game phase, integer scores, previous hit levels
    int          m_phase;   // 0 idle, 1 playing, 2 game-over cycle
    int          m_score, m_best;
    logic        m_cout;
    logic [7:0]  m_prev;

    wam_scr_multi #(.NUM_HOLES(8), .DIGITS(3), .PTS_PER_HIT(1)) dut (
        .clk(clk), .clr(clr), .start(start), .stop(stop),
        .hit(hit), .mole(mole), .num(num), .best(best),
        .cout0(cout0), .playing(playing)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] bcd(input int v);
        logic [11:0] r;
        int x;
        x = v;
        r = '0;
        for (int d = 0; d < 3; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_score = 0; m_best = 0; m_cout = 1'b0; m_prev = '0;
    endtask

    task automatic model_eval();
        logic [7:0] r;
        int v, ms;
        r = hit & ~m_prev;
        case (m_phase)
            0: if (start) begin m_phase = 1; m_score = 0; m_cout = 1'b0; end
            1: if (stop) m_phase = 2;
               else begin
                   v = m_score + $countones(r & mole);
`ifdef WAM_MISS_PENALTY_EN
                   ms = $countones(r & ~mole);
                   v = (v - ms < 0) ? 0 : v - ms;
`else
                   ms = 0;
`endif
                   if (v >= 999) begin m_score = 999; m_cout = 1'b1; end
                   else m_score = v;
               end
            default: begin
                if (m_score > m_best) m_best = m_score;
                m_phase = 0;
            end
        endcase
        m_prev = hit;
    endtask

    task automatic model_compare();
        check("num",     32'(num),     32'(bcd(m_score)));
        check("best",    32'(best),    32'(bcd(m_best)));
        check("cout0",   32'(cout0),   32'(m_cout));
        check("playing", 32'(playing), 32'(m_phase == 1));
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        #1;
        model_compare();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    // asynchronous clear in the middle of a cycle, checked before any edge
    task automatic do_clr();
        #2 clr = 1'b1;
        #1;
        check("clr_num",     32'(num),     32'h0);
        check("clr_best",    32'(best),    32'h0);
        check("clr_cout0",   32'(cout0),   32'h0);
        check("clr_playing", 32'(playing), 32'h0);
        model_reset();
        #1 clr = 1'b0;
    endtask

    typedef struct {
        logic        st, sp;
        logic [7:0]  h, m;
        logic [11:0] en, eb;
        logic        ep;
    } vec_t;

`ifdef WAM_MISS_PENALTY_EN
    localparam logic [11:0] S7 = 12'h001;
`else
    localparam logic [11:0] S7 = 12'h005;
`endif

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 8'h01, 12'h000, 12'h000, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 8'h01, 8'h01, 12'h001, 12'h000, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 8'h01, 8'h01, 12'h001, 12'h000, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 8'h01, 8'h01, 12'h001, 12'h000, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 8'h01, 8'h01, 12'h001, 12'h000, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 8'h01, 8'h01, 12'h001, 12'h000, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 8'h00, 8'h0F, 12'h001, 12'h000, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 8'hFF, 8'h0F, S7,      12'h000, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 8'h0F, S7,      12'h000, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 8'hFF, 8'hFF, S7,      12'h000, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 8'h00, 8'h00, S7,      S7,      1'b0};
        tbl[11] = '{1'b1, 1'b1, 8'h00, 8'h00, 12'h000, S7,      1'b1};

        // clear at time zero with hit toggling, before the first clock edge
        clr = 1'b1; start = 1'b0; stop = 1'b0; hit = '0; mole = '0;
        model_reset();
        #1 hit = 8'hFF;
        #1 hit = 8'h00;
        #1;
        check("t0_num",     32'(num),     32'h0);
        check("t0_best",    32'(best),    32'h0);
        check("t0_cout0",   32'(cout0),   32'h0);
        check("t0_playing", 32'(playing), 32'h0);
        #1 clr = 1'b0;

        for (int i = 0; i < 12; i++) begin
            start = tbl[i].st; stop = tbl[i].sp; hit = tbl[i].h; mole = tbl[i].m;
            step();
            check($sformatf("vec%0d_num", i),     32'(num),     32'(tbl[i].en));
            check($sformatf("vec%0d_best", i),    32'(best),    32'(tbl[i].eb));
            check($sformatf("vec%0d_playing", i), 32'(playing), 32'(tbl[i].ep));
        end
        stop = 1'b1; step();
        step();

        // drive the score up to 998, then finish with four simultaneous hits
        start = 1'b1; hit = '0; mole = 8'hFF; step();
        while (m_score < 992) begin
            hit = ~hit; step();
        end
        while (m_score < 998) begin
            hit = 8'h00; step();
            hit = 8'h01; mole = 8'h01; step();
        end
        check("pre_sat_num", 32'(num), 32'h998);
        hit = 8'h00; step();
        hit = 8'h0F; mole = 8'h0F; step();
        check("sat_num",   32'(num),   32'h999);
        check("sat_cout0", 32'(cout0), 32'h1);
        hit = 8'h00; step();
        hit = 8'h0F; step();
        check("sat_hold", 32'(num), 32'h999);
        hit = 8'h00; stop = 1'b1; step();
        step();
        check("sat_best", 32'(best), 32'h999);
        start = 1'b1; step();
        check("restart_num",   32'(num),   32'h0);
        check("restart_cout0", 32'(cout0), 32'h0);

        // clear during a game drops best
        mole = 8'hFF; hit = 8'hFF; step();
        hit = 8'h00; step();
        do_clr();
        check("midgame_clr_best", 32'(best), 32'h0);

        // first edge after clear: high hit counts as a rise
        start = 1'b1; hit = 8'h00; step();
        hit = 8'h03; mole = 8'h03; step();
        check("post_clr_rise", 32'(num), 32'h002);
        stop = 1'b1; step();
        step();

`ifdef WAM_MISS_PENALTY_EN
        start = 1'b1; hit = 8'h00; step();
        hit = 8'h01; mole = 8'h00; step();
        check("pen_floor", 32'(num), 32'h000);
        hit = 8'h00; step();
        hit = 8'h1F; mole = 8'h1F; step();
        hit = 8'h00; step();
        hit = 8'hF0; mole = 8'h10; step();
        check("pen_net", 32'(num), 32'h003);
        stop = 1'b1; step();
        step();
`endif

        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 2) != 0) hit = 8'($urandom);
            mole  = 8'($urandom);
            step();
            if ($urandom_range(0, 199) == 0) begin
                hit = 8'($urandom);
                do_clr();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
